// File: rtl/multi_vc_input_buffer.sv
// ---------------------------------------------------------------------------
// multi_vc_input_buffer
//   Router input port with VC_NUM independent virtual-channel FIFOs. Each VC
//   runs its own packet state machine (IDLE -> VA -> ACTIVE -> IDLE). The VC
//   asks the VC allocator for a downstream VC, rewrites vc_id on the way out,
//   and returns flow control to the upstream router.
//
// Optional feature macro: MULTI_VC_INPUT_BUFFER_CREDIT_EN
//   defined   : credit_o[v] is a one-cycle pulse after each successful read
//   undefined : on_off_o[v] is a level, 0 while free slots <= ON_OFF_THRESHOLD
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   data_i, write_i   incoming flit and its write strobe (data_i.vc_id = VC)
//   out_port_i[v]     route result, latched on a HEAD write to VC v
//   read_i[v]         pop the front flit of VC v
//   vc_valid_i[v]     VC allocator grant, vc_new_i[v] is the granted VC
//   data_o[v]         front flit (fall-through), vc_id rewritten when ACTIVE
//   is_full_o/is_empty_o[v]   FIFO occupancy flags
//   out_port_o[v]     latched route
//   vc_request_o[v]   request to the VC allocator
//   vc_allocatable_o[v]  VC idle and drained
//   credit_o / on_off_o  flow-control return
//   error_o           one-cycle protocol-violation pulse
// ---------------------------------------------------------------------------
package noc_params;
  localparam int unsigned VC_NUM  = 2;
  localparam int unsigned VC_SIZE = $clog2(VC_NUM);
  localparam int unsigned DATA_W  = 16;

  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;
  typedef enum logic [1:0] {HEAD, BODY, TAIL} flit_label_t;

  typedef struct packed {
    flit_label_t          flit_label;
    logic [VC_SIZE-1:0]   vc_id;
    logic [DATA_W-1:0]    data;
  } flit_t;
endpackage

module multi_vc_input_buffer #(
  parameter  int unsigned VC_NUM           = 2,
  parameter  int unsigned BUFFER_SIZE      = 8,
  parameter  int unsigned ON_OFF_THRESHOLD = 2,
  localparam int unsigned VC_SIZE          = $clog2(VC_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  noc_params::flit_t     data_i,
  input  logic                  write_i,
  input  noc_params::port_t     out_port_i   [VC_NUM],
  input  logic [VC_NUM-1:0]     read_i,
  input  logic [VC_NUM-1:0]     vc_valid_i,
  input  logic [VC_SIZE-1:0]    vc_new_i     [VC_NUM],
  output noc_params::flit_t     data_o       [VC_NUM],
  output logic [VC_NUM-1:0]     is_full_o,
  output logic [VC_NUM-1:0]     is_empty_o,
  output noc_params::port_t     out_port_o   [VC_NUM],
  output logic [VC_NUM-1:0]     vc_request_o,
  output logic [VC_NUM-1:0]     vc_allocatable_o,
`ifdef MULTI_VC_INPUT_BUFFER_CREDIT_EN
  output logic [VC_NUM-1:0]     credit_o,
`else
  output logic [VC_NUM-1:0]     on_off_o,
`endif
  output logic                  error_o
);
  import noc_params::*;

  localparam int unsigned IDX_W     = $clog2(BUFFER_SIZE);
  localparam int unsigned PTR_W     = IDX_W + 1;
  localparam int unsigned FLIT_VC_W = noc_params::VC_SIZE;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_VA     = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  // Storage and per-VC registers
  flit_t              r_mem        [VC_NUM][BUFFER_SIZE];
  logic [1:0]         r_state      [VC_NUM];
  logic [PTR_W-1:0]   r_wr_ptr     [VC_NUM];
  logic [PTR_W-1:0]   r_rd_ptr     [VC_NUM];
  port_t              r_out_port   [VC_NUM];
  logic [VC_SIZE-1:0] r_vc_new     [VC_NUM];
  logic [VC_NUM-1:0]  r_is_full;
  logic [VC_NUM-1:0]  r_is_empty;
  logic [VC_NUM-1:0]  r_vc_request;
  logic [VC_NUM-1:0]  r_allocatable;
  logic [VC_NUM-1:0]  r_flow;
  logic               r_error;

  // Next-state values
  logic [1:0]         w_state_nxt  [VC_NUM];
  logic [PTR_W-1:0]   w_wr_ptr_nxt [VC_NUM];
  logic [PTR_W-1:0]   w_rd_ptr_nxt [VC_NUM];
  port_t              w_out_port_nxt [VC_NUM];
  logic [VC_SIZE-1:0] w_vc_new_nxt [VC_NUM];
  logic [VC_NUM-1:0]  w_wr_ok;
  logic [VC_NUM-1:0]  w_rd_ok;
  logic [VC_NUM-1:0]  w_full_nxt;
  logic [VC_NUM-1:0]  w_empty_nxt;
  logic [VC_NUM-1:0]  w_flow_nxt;
  logic               w_vc_hit;
  logic               w_error_nxt;
`ifndef MULTI_VC_INPUT_BUFFER_CREDIT_EN
  logic [PTR_W-1:0]   w_free       [VC_NUM];
`endif

  // Per-VC FSM, FIFO pointer and error decode
  always_comb begin : next_state_logic
    w_vc_hit    = 1'b0;
    w_error_nxt = 1'b0;
    w_wr_ok     = '0;
    w_rd_ok     = '0;
    w_full_nxt  = '0;
    w_empty_nxt = '0;
    w_flow_nxt  = '0;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      w_state_nxt[v]    = r_state[v];
      w_out_port_nxt[v] = r_out_port[v];
      w_vc_new_nxt[v]   = r_vc_new[v];
`ifndef MULTI_VC_INPUT_BUFFER_CREDIT_EN
      w_free[v]         = PTR_W'(BUFFER_SIZE) - (r_wr_ptr[v] - r_rd_ptr[v]);
`endif

      // Write side: full check wins even if the same VC is read this cycle
      if (write_i && (data_i.vc_id == FLIT_VC_W'(v))) begin
        w_vc_hit = 1'b1;
        if (r_is_full[v]) begin
          w_error_nxt = 1'b1;
        end else if (data_i.flit_label == HEAD) begin
          if (r_state[v] != ST_IDLE) begin
            w_error_nxt = 1'b1;
          end else begin
            w_wr_ok[v]        = 1'b1;
            w_out_port_nxt[v] = out_port_i[v];
            w_state_nxt[v]    = ST_VA;
          end
        end else if (r_state[v] == ST_IDLE) begin
          w_error_nxt = 1'b1;
        end else begin
          w_wr_ok[v] = 1'b1;
        end
      end

      // Read side: only an ACTIVE, non-empty VC may be popped
      if (read_i[v]) begin
        if (r_is_empty[v] || (r_state[v] != ST_ACTIVE)) begin
          w_error_nxt = 1'b1;
        end else begin
          w_rd_ok[v] = 1'b1;
          if (r_mem[v][r_rd_ptr[v][IDX_W-1:0]].flit_label == TAIL) begin
            w_state_nxt[v] = ST_IDLE;
          end
        end
      end

      // Grants are meaningful only while requesting
      if ((r_state[v] == ST_VA) && vc_valid_i[v]) begin
        w_state_nxt[v]  = ST_ACTIVE;
        w_vc_new_nxt[v] = vc_new_i[v];
      end

      w_wr_ptr_nxt[v] = r_wr_ptr[v] + PTR_W'(w_wr_ok[v]);
      w_rd_ptr_nxt[v] = r_rd_ptr[v] + PTR_W'(w_rd_ok[v]);
      w_empty_nxt[v]  = (w_wr_ptr_nxt[v] == w_rd_ptr_nxt[v]);
      w_full_nxt[v]   = (w_wr_ptr_nxt[v][PTR_W-1] != w_rd_ptr_nxt[v][PTR_W-1]) &&
                        (w_wr_ptr_nxt[v][IDX_W-1:0] == w_rd_ptr_nxt[v][IDX_W-1:0]);
`ifdef MULTI_VC_INPUT_BUFFER_CREDIT_EN
      w_flow_nxt[v]   = w_rd_ok[v];
`else
      // Level follows the current occupancy, so it trails a write by a cycle
      w_flow_nxt[v]   = (w_free[v] > PTR_W'(ON_OFF_THRESHOLD));
`endif
    end
    // A vc_id that names no VC is also a protocol violation
    if (write_i && !w_vc_hit) begin
      w_error_nxt = 1'b1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin : state_regs
    if (rst) begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        r_state[v]    <= ST_IDLE;
        r_wr_ptr[v]   <= '0;
        r_rd_ptr[v]   <= '0;
        r_out_port[v] <= LOCAL;
        r_vc_new[v]   <= '0;
      end
      r_is_full     <= '0;
      r_is_empty    <= '1;
      r_vc_request  <= '0;
      r_allocatable <= '1;
`ifdef MULTI_VC_INPUT_BUFFER_CREDIT_EN
      r_flow        <= '0;
`else
      r_flow        <= '1;
`endif
      r_error       <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        r_state[v]       <= w_state_nxt[v];
        r_wr_ptr[v]      <= w_wr_ptr_nxt[v];
        r_rd_ptr[v]      <= w_rd_ptr_nxt[v];
        r_out_port[v]    <= w_out_port_nxt[v];
        r_vc_new[v]      <= w_vc_new_nxt[v];
        r_vc_request[v]  <= (w_state_nxt[v] == ST_VA);
        r_allocatable[v] <= (w_state_nxt[v] == ST_IDLE) && w_empty_nxt[v];
      end
      r_is_full  <= w_full_nxt;
      r_is_empty <= w_empty_nxt;
      r_flow     <= w_flow_nxt;
      r_error    <= w_error_nxt;
    end
  end

  // Flit storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin : fifo_mem
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      if (w_wr_ok[v]) begin
        r_mem[v][r_wr_ptr[v][IDX_W-1:0]] <= data_i;
      end
    end
  end

  // Fall-through front flit with downstream VC substituted once allocated
  always_comb begin : front_flit
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      data_o[v] = r_mem[v][r_rd_ptr[v][IDX_W-1:0]];
      if (r_state[v] == ST_ACTIVE) begin
        data_o[v].vc_id = FLIT_VC_W'(r_vc_new[v]);
      end
    end
  end

  assign is_full_o        = r_is_full;
  assign is_empty_o       = r_is_empty;
  assign out_port_o       = r_out_port;
  assign vc_request_o     = r_vc_request;
  assign vc_allocatable_o = r_allocatable;
`ifdef MULTI_VC_INPUT_BUFFER_CREDIT_EN
  assign credit_o         = r_flow;
`else
  assign on_off_o         = r_flow;
`endif
  assign error_o          = r_error;

endmodule

// File: tb/tb_multi_vc_input_buffer.sv
// ---------------------------------------------------------------------------
// tb_multi_vc_input_buffer
//   Directed self-checking bench for multi_vc_input_buffer (VC_NUM=2,
//   BUFFER_SIZE=8, ON_OFF_THRESHOLD=2). Inputs change 1 time unit after the
//   rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_multi_vc_input_buffer;
  import noc_params::*;

  localparam int unsigned VCN = 2;
  localparam int unsigned VCS = 1;

  logic              clk = 1'b0;
  logic              rst;
  flit_t             data_i;
  logic              write_i;
  port_t             out_port_i [VCN];
  logic [VCN-1:0]    read_i;
  logic [VCN-1:0]    vc_valid_i;
  logic [VCS-1:0]    vc_new_i   [VCN];
  flit_t             data_o     [VCN];
  logic [VCN-1:0]    is_full_o;
  logic [VCN-1:0]    is_empty_o;
  port_t             out_port_o [VCN];
  logic [VCN-1:0]    vc_request_o;
  logic [VCN-1:0]    vc_allocatable_o;
`ifdef MULTI_VC_INPUT_BUFFER_CREDIT_EN
  logic [VCN-1:0]    credit_o;
`else
  logic [VCN-1:0]    on_off_o;
`endif
  logic              error_o;

  int n_vec = 0;
  int n_err = 0;

  multi_vc_input_buffer #(
    .VC_NUM(VCN), .BUFFER_SIZE(8), .ON_OFF_THRESHOLD(2)
  ) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .write_i(write_i),
    .out_port_i(out_port_i), .read_i(read_i), .vc_valid_i(vc_valid_i),
    .vc_new_i(vc_new_i), .data_o(data_o), .is_full_o(is_full_o),
    .is_empty_o(is_empty_o), .out_port_o(out_port_o),
    .vc_request_o(vc_request_o), .vc_allocatable_o(vc_allocatable_o),
`ifdef MULTI_VC_INPUT_BUFFER_CREDIT_EN
    .credit_o(credit_o),
`else
    .on_off_o(on_off_o),
`endif
    .error_o(error_o)
  );

  always #5 clk = ~clk;

  function automatic flit_t mk(flit_label_t l, int unsigned vc, int unsigned d);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = VCS'(vc);
    f.data       = 16'(d);
    return f;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet;
    write_i    = 1'b0;
    read_i     = '0;
    vc_valid_i = '0;
  endtask

  task automatic wr(flit_label_t l, int unsigned vc, int unsigned d);
    data_i  = mk(l, vc, d);
    write_i = 1'b1;
    tick();
    write_i = 1'b0;
  endtask

  task automatic test_reset;
    quiet();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (is_empty_o !== 2'b11) begin n_err++; $display("FAIL reset is_empty: got %b expected 11", is_empty_o); end
    n_vec++; if (is_full_o !== 2'b00) begin n_err++; $display("FAIL reset is_full: got %b expected 00", is_full_o); end
    n_vec++; if (vc_request_o !== 2'b00) begin n_err++; $display("FAIL reset vc_request: got %b expected 00", vc_request_o); end
    n_vec++; if (vc_allocatable_o !== 2'b11) begin n_err++; $display("FAIL reset allocatable: got %b expected 11", vc_allocatable_o); end
    n_vec++; if (out_port_o[0] !== LOCAL || out_port_o[1] !== LOCAL) begin n_err++; $display("FAIL reset out_port: got %0d/%0d expected LOCAL", out_port_o[0], out_port_o[1]); end
`ifdef MULTI_VC_INPUT_BUFFER_CREDIT_EN
    n_vec++; if (credit_o !== 2'b00) begin n_err++; $display("FAIL reset credit: got %b expected 00", credit_o); end
`else
    n_vec++; if (on_off_o !== 2'b11) begin n_err++; $display("FAIL reset on_off: got %b expected 11", on_off_o); end
`endif
    n_vec++; if (error_o !== 1'b0) begin n_err++; $display("FAIL reset error: got %b expected 0", error_o); end
  endtask

  task automatic test_single_packet;
    flit_label_t lb [4] = '{HEAD, BODY, BODY, TAIL};
    out_port_i[0] = NORTH;
    for (int i = 0; i < 4; i++) begin
      wr(lb[i], 0, 16'h1000 + i);
      n_vec++; if (vc_request_o[0] !== 1'b1) begin n_err++; $display("FAIL single vc_request wr%0d: got %b expected 1", i, vc_request_o[0]); end
    end
    n_vec++; if (out_port_o[0] !== NORTH) begin n_err++; $display("FAIL single out_port: got %0d expected NORTH", out_port_o[0]); end
    n_vec++; if (vc_allocatable_o[0] !== 1'b0) begin n_err++; $display("FAIL single allocatable busy: got %b expected 0", vc_allocatable_o[0]); end
    vc_valid_i[0] = 1'b1; vc_new_i[0] = 1'b1;
    tick();
    vc_valid_i = '0;
    n_vec++; if (vc_request_o[0] !== 1'b0) begin n_err++; $display("FAIL single vc_request after grant: got %b expected 0", vc_request_o[0]); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (data_o[0] !== mk(lb[i], 1, 16'h1000 + i)) begin n_err++; $display("FAIL single data rd%0d: got %h expected %h", i, data_o[0], mk(lb[i], 1, 16'h1000 + i)); end
      read_i[0] = 1'b1;
      tick();
      read_i = '0;
      n_vec++; if (error_o !== 1'b0) begin n_err++; $display("FAIL single error rd%0d: got %b expected 0", i, error_o); end
    end
    n_vec++; if (vc_allocatable_o[0] !== 1'b1) begin n_err++; $display("FAIL single allocatable after tail: got %b expected 1", vc_allocatable_o[0]); end
    n_vec++; if (is_empty_o[0] !== 1'b1) begin n_err++; $display("FAIL single empty after tail: got %b expected 1", is_empty_o[0]); end
  endtask

  task automatic test_interleaved;
    flit_label_t lb [3] = '{HEAD, BODY, TAIL};
    out_port_i[0] = WEST;
    out_port_i[1] = EAST;
    for (int i = 0; i < 3; i++) begin
      for (int v = 0; v < 2; v++) begin
        wr(lb[i], v, 16'h2000 + v * 16'h100 + i);
        n_vec++; if (error_o !== 1'b0) begin n_err++; $display("FAIL interleave write error vc%0d #%0d: got %b expected 0", v, i, error_o); end
      end
    end
    n_vec++; if (out_port_o[0] !== WEST || out_port_o[1] !== EAST) begin n_err++; $display("FAIL interleave out_port: got %0d/%0d expected WEST/EAST", out_port_o[0], out_port_o[1]); end
    vc_valid_i = 2'b11; vc_new_i[0] = 1'b1; vc_new_i[1] = 1'b0;
    tick();
    vc_valid_i = '0;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (data_o[0] !== mk(lb[i], 1, 16'h2000 + i)) begin n_err++; $display("FAIL interleave vc0 rd%0d: got %h expected %h", i, data_o[0], mk(lb[i], 1, 16'h2000 + i)); end
      n_vec++; if (data_o[1] !== mk(lb[i], 0, 16'h2100 + i)) begin n_err++; $display("FAIL interleave vc1 rd%0d: got %h expected %h", i, data_o[1], mk(lb[i], 0, 16'h2100 + i)); end
      read_i = 2'b11;
      tick();
      read_i = '0;
      n_vec++; if (error_o !== 1'b0) begin n_err++; $display("FAIL interleave read error rd%0d: got %b expected 0", i, error_o); end
    end
    n_vec++; if (vc_allocatable_o !== 2'b11) begin n_err++; $display("FAIL interleave allocatable: got %b expected 11", vc_allocatable_o); end
  endtask

  task automatic test_full_wrap;
    out_port_i[0] = SOUTH;
    wr(HEAD, 0, 16'h3000);
    for (int i = 1; i < 8; i++) wr(BODY, 0, 16'h3000 + i);
    n_vec++; if (is_full_o[0] !== 1'b1) begin n_err++; $display("FAIL full flag after 8: got %b expected 1", is_full_o[0]); end
    wr(BODY, 0, 16'h30FF);
    n_vec++; if (error_o !== 1'b1) begin n_err++; $display("FAIL full 9th write error: got %b expected 1", error_o); end
    n_vec++; if (is_full_o[0] !== 1'b1) begin n_err++; $display("FAIL full flag after 9th: got %b expected 1", is_full_o[0]); end
    vc_valid_i[0] = 1'b1; vc_new_i[0] = 1'b1;
    tick();
    vc_valid_i = '0;
    n_vec++; if (error_o !== 1'b0) begin n_err++; $display("FAIL full error pulse width: got %b expected 0", error_o); end
    // Read and write together while full: write dropped, read honoured
    n_vec++; if (data_o[0] !== mk(HEAD, 1, 16'h3000)) begin n_err++; $display("FAIL full front: got %h expected %h", data_o[0], mk(HEAD, 1, 16'h3000)); end
    data_i = mk(BODY, 0, 16'h30EE); write_i = 1'b1; read_i[0] = 1'b1;
    tick();
    quiet();
    n_vec++; if (error_o !== 1'b1) begin n_err++; $display("FAIL full rw error: got %b expected 1", error_o); end
    n_vec++; if (is_full_o[0] !== 1'b0) begin n_err++; $display("FAIL full rw flag: got %b expected 0", is_full_o[0]); end
    for (int i = 1; i < 8; i++) begin
      n_vec++; if (data_o[0] !== mk(BODY, 1, 16'h3000 + i)) begin n_err++; $display("FAIL full drain rd%0d: got %h expected %h", i, data_o[0], mk(BODY, 1, 16'h3000 + i)); end
      read_i[0] = 1'b1;
      tick();
      read_i = '0;
    end
    n_vec++; if (is_empty_o[0] !== 1'b1) begin n_err++; $display("FAIL full drained empty: got %b expected 1", is_empty_o[0]); end
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) wr((r == 2 && i == 4) ? TAIL : BODY, 0, 16'h3100 + r * 16 + i);
      for (int i = 0; i < 5; i++) begin
        n_vec++; if (data_o[0] !== mk((r == 2 && i == 4) ? TAIL : BODY, 1, 16'h3100 + r * 16 + i)) begin n_err++; $display("FAIL wrap round%0d rd%0d: got %h", r, i, data_o[0]); end
        read_i[0] = 1'b1;
        tick();
        read_i = '0;
      end
      n_vec++; if (is_empty_o[0] !== 1'b1) begin n_err++; $display("FAIL wrap round%0d empty: got %b expected 1", r, is_empty_o[0]); end
    end
    n_vec++; if (vc_allocatable_o[0] !== 1'b1) begin n_err++; $display("FAIL wrap allocatable: got %b expected 1", vc_allocatable_o[0]); end
  endtask

  task automatic test_protocol_errors;
    wr(BODY, 0, 16'h4001);
    n_vec++; if (error_o !== 1'b1) begin n_err++; $display("FAIL perr body-to-idle error: got %b expected 1", error_o); end
    n_vec++; if (is_empty_o[0] !== 1'b1 || vc_request_o[0] !== 1'b0) begin n_err++; $display("FAIL perr body-to-idle state: got empty %b req %b expected 1/0", is_empty_o[0], vc_request_o[0]); end
    out_port_i[0] = WEST;
    wr(HEAD, 0, 16'h4002);
    n_vec++; if (error_o !== 1'b0) begin n_err++; $display("FAIL perr head accepted: got error %b expected 0", error_o); end
    read_i[0] = 1'b1;
    tick();
    read_i = '0;
    n_vec++; if (error_o !== 1'b1) begin n_err++; $display("FAIL perr read-in-VA error: got %b expected 1", error_o); end
    n_vec++; if (is_empty_o[0] !== 1'b0 || vc_request_o[0] !== 1'b1) begin n_err++; $display("FAIL perr read-in-VA state: got empty %b req %b expected 0/1", is_empty_o[0], vc_request_o[0]); end
    vc_valid_i[0] = 1'b1; vc_new_i[0] = 1'b1;
    tick();
    vc_valid_i = '0;
    wr(HEAD, 0, 16'h4003);
    n_vec++; if (error_o !== 1'b1) begin n_err++; $display("FAIL perr head-to-active error: got %b expected 1", error_o); end
    n_vec++; if (data_o[0] !== mk(HEAD, 1, 16'h4002)) begin n_err++; $display("FAIL perr head-to-active front: got %h expected %h", data_o[0], mk(HEAD, 1, 16'h4002)); end
    read_i[0] = 1'b1;
    tick();
    n_vec++; if (is_empty_o[0] !== 1'b1 || error_o !== 1'b0) begin n_err++; $display("FAIL perr single entry: got empty %b error %b expected 1/0", is_empty_o[0], error_o); end
    tick();
    read_i = '0;
    n_vec++; if (error_o !== 1'b1) begin n_err++; $display("FAIL perr read-empty error: got %b expected 1", error_o); end
    wr(TAIL, 0, 16'h4004);
    read_i[0] = 1'b1;
    tick();
    read_i = '0;
    n_vec++; if (vc_allocatable_o[0] !== 1'b1 || error_o !== 1'b0) begin n_err++; $display("FAIL perr recovery: got alloc %b error %b expected 1/0", vc_allocatable_o[0], error_o); end
  endtask

`ifdef MULTI_VC_INPUT_BUFFER_CREDIT_EN
  task automatic test_flow_control;
    flit_label_t lb [4] = '{HEAD, BODY, BODY, TAIL};
    out_port_i[1] = NORTH;
    for (int i = 0; i < 4; i++) wr(lb[i], 1, 16'h5000 + i);
    vc_valid_i[1] = 1'b1; vc_new_i[1] = 1'b0;
    tick();
    vc_valid_i = '0;
    for (int i = 0; i < 4; i++) begin
      read_i[1] = 1'b1;
      tick();
      read_i = '0;
      n_vec++; if (credit_o[1] !== 1'b1) begin n_err++; $display("FAIL credit pulse rd%0d: got %b expected 1", i, credit_o[1]); end
      tick();
      n_vec++; if (credit_o[1] !== 1'b0) begin n_err++; $display("FAIL credit low rd%0d: got %b expected 0", i, credit_o[1]); end
    end
  endtask
`else
  task automatic test_flow_control;
    flit_label_t lb [6] = '{HEAD, BODY, BODY, BODY, BODY, TAIL};
    out_port_i[1] = NORTH;
    for (int i = 0; i < 6; i++) wr(lb[i], 1, 16'h5000 + i);
    n_vec++; if (on_off_o[1] !== 1'b1) begin n_err++; $display("FAIL on_off at 6th write: got %b expected 1", on_off_o[1]); end
    tick();
    n_vec++; if (on_off_o[1] !== 1'b0) begin n_err++; $display("FAIL on_off one cycle later: got %b expected 0", on_off_o[1]); end
    vc_valid_i[1] = 1'b1; vc_new_i[1] = 1'b0;
    tick();
    vc_valid_i = '0;
    read_i[1] = 1'b1;
    tick();
    read_i = '0;
    n_vec++; if (on_off_o[1] !== 1'b0) begin n_err++; $display("FAIL on_off at read edge: got %b expected 0", on_off_o[1]); end
    tick();
    n_vec++; if (on_off_o[1] !== 1'b1) begin n_err++; $display("FAIL on_off after read: got %b expected 1", on_off_o[1]); end
    read_i[1] = 1'b1;
    for (int i = 1; i < 6; i++) tick();
    read_i = '0;
    n_vec++; if (vc_allocatable_o[1] !== 1'b1 || error_o !== 1'b0) begin n_err++; $display("FAIL on_off drain: got alloc %b error %b expected 1/0", vc_allocatable_o[1], error_o); end
  endtask
`endif

  task automatic test_reset_mid_packet;
    out_port_i[1] = SOUTH;
    wr(HEAD, 1, 16'h6000);
    wr(BODY, 1, 16'h6001);
    n_vec++; if (vc_request_o[1] !== 1'b1 || out_port_o[1] !== SOUTH) begin n_err++; $display("FAIL midrst pre state: got req %b port %0d expected 1/SOUTH", vc_request_o[1], out_port_o[1]); end
    test_reset();
    wr(BODY, 1, 16'h6002);
    n_vec++; if (error_o !== 1'b1) begin n_err++; $display("FAIL midrst body-after-reset error: got %b expected 1", error_o); end
    n_vec++; if (is_empty_o[1] !== 1'b1) begin n_err++; $display("FAIL midrst body-after-reset empty: got %b expected 1", is_empty_o[1]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    data_i        = '0;
    out_port_i[0] = LOCAL;
    out_port_i[1] = LOCAL;
    vc_new_i[0]   = '0;
    vc_new_i[1]   = '0;
    quiet();
    tick();
    test_reset();
    test_single_packet();
    test_interleaved();
    test_full_wrap();
    test_protocol_errors();
    test_flow_control();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
